// File: rtl/wb_pkg.sv
// Shared constants and entry type for the register writeback queue.
package wb_pkg;
  localparam int WB_ADDR_W = 5;
  localparam int WB_DATA_W = 32;

  typedef struct packed {
    logic [WB_ADDR_W-1:0] idx;
    logic [WB_DATA_W-1:0] data;
  } wb_entry_t;

  function automatic int wbCountW(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/reg_writeback_queue_if.sv
// Result producers (ALU, load unit) and the register-file write port of the writeback queue.
interface reg_writeback_queue_if
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W
);
  logic              AluValid;
  logic [ADDR_W-1:0] AluReg;
  logic [DATA_W-1:0] AluData;
  logic              MemValid;
  logic [ADDR_W-1:0] MemReg;
  logic [DATA_W-1:0] MemData;
  logic              MemReady;
  logic [ADDR_W-1:0] WriteReg1;
  logic [DATA_W-1:0] WriteData1;
  logic              Write1;

  modport master (
    output AluValid, AluReg, AluData, MemValid, MemReg, MemData,
    input  MemReady, WriteReg1, WriteData1, Write1
  );

  modport slave (
    input  AluValid, AluReg, AluData, MemValid, MemReg, MemData,
    output MemReady, WriteReg1, WriteData1, Write1
  );
endinterface

// File: rtl/wb_dual_enq_fifo.sv
// Circular FIFO with two write ports (A ordered ahead of B) and one read port; storage is exposed for lookups.
module wb_dual_enq_fifo #(
  parameter int DEPTH   = 4,
  parameter int ENTRY_W = 37,
  localparam int PW     = $clog2(DEPTH),
  localparam int CW     = PW + 1
) (
  input  logic               CLK,
  input  logic               RESET,
  input  logic               enqA,
  input  logic [ENTRY_W-1:0] entryA,
  input  logic               enqB,
  input  logic [ENTRY_W-1:0] entryB,
  input  logic               deq,
  output logic [ENTRY_W-1:0] slots [DEPTH],
  output logic [PW-1:0]      rdPtr,
  output logic [CW-1:0]      count
);
  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wrPtr;

  assign slots = mem;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      wrPtr <= wrPtr + PW'(enqA) + PW'(enqB);
      rdPtr <= rdPtr + PW'(deq);
      count <= count + CW'(enqA) + CW'(enqB) - CW'(deq);
    end
  end

  // Storage carries no reset; occupancy alone decides which slots are meaningful.
  always_ff @(posedge CLK) begin
    if (enqA) mem[wrPtr] <= entryA;
    if (enqB) mem[enqA ? wrPtr + PW'(1) : wrPtr] <= entryB;
  end
endmodule

// File: rtl/reg_writeback_queue.sv
// Merges ALU and load results into one in-order queue draining onto register-file write port 1,
// with pending-write lookups for decode. Define WB_FWD_EN to add FwdDataA/B/C forwarding outputs.
module reg_writeback_queue
  import wb_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = WB_DATA_W,
  parameter int ADDR_W = WB_ADDR_W,
  localparam int CW    = wbCountW(DEPTH)
) (
  input  logic              CLK,
  input  logic              RESET,
  reg_writeback_queue_if.slave wb,
  input  logic [ADDR_W-1:0] QryA,
  input  logic [ADDR_W-1:0] QryB,
  input  logic [ADDR_W-1:0] QryC,
  output logic              PendA,
  output logic              PendB,
  output logic              PendC,
  output logic [CW-1:0]     Count,
`ifdef WB_FWD_EN
  output logic [DATA_W-1:0] FwdDataA,
  output logic [DATA_W-1:0] FwdDataB,
  output logic [DATA_W-1:0] FwdDataC,
`endif
  output logic              Overflow
);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = ADDR_W + DATA_W;

  logic              full, enqAlu, enqMem, deq;
  logic [EW-1:0]     slots [DEPTH];
  logic [PW-1:0]     rdPtr;
  logic [EW-1:0]     head;
  logic [ADDR_W-1:0] qry [3];
  logic [2:0]        pend;
  logic [EW-1:0]     slot;

  // Room is judged on registered Count; MemReady keeps one slot free for the unstallable ALU.
  assign full        = (Count == CW'(DEPTH));
  assign wb.MemReady = (Count <= CW'(DEPTH - 2));
  assign enqAlu      = wb.AluValid && (wb.AluReg != '0) && !full;
  assign enqMem      = wb.MemValid && wb.MemReady && (wb.MemReg != '0);
  assign deq         = (Count != '0);

  wb_dual_enq_fifo #(.DEPTH(DEPTH), .ENTRY_W(EW)) uFifo (
    .CLK    (CLK),
    .RESET  (RESET),
    .enqA   (enqAlu),
    .entryA ({wb.AluReg, wb.AluData}),
    .enqB   (enqMem),
    .entryB ({wb.MemReg, wb.MemData}),
    .deq    (deq),
    .slots  (slots),
    .rdPtr  (rdPtr),
    .count  (Count)
  );

  assign head          = slots[rdPtr];
  assign wb.Write1     = deq;
  assign wb.WriteReg1  = deq ? head[EW-1:DATA_W] : '0;
  assign wb.WriteData1 = deq ? head[DATA_W-1:0] : '0;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) Overflow <= 1'b0;
    else if (wb.AluValid && (wb.AluReg != '0) && full) Overflow <= 1'b1;
  end

  assign qry   = '{QryA, QryB, QryC};
  assign PendA = pend[0];
  assign PendB = pend[1];
  assign PendC = pend[2];

  always_comb begin
    pend = '0;
    slot = '0;
    for (int q = 0; q < 3; q++) begin
      for (int k = 0; k < DEPTH; k++) begin
        slot = slots[rdPtr + PW'(k)];
        if ((CW'(k) < Count) && (slot[EW-1:DATA_W] == qry[q])) pend[q] = 1'b1;
      end
      if (wb.AluValid && (wb.AluReg == qry[q])) pend[q] = 1'b1;
      if (wb.MemValid && wb.MemReady && (wb.MemReg == qry[q])) pend[q] = 1'b1;
      if (qry[q] == '0) pend[q] = 1'b0;
    end
  end

`ifdef WB_FWD_EN
  logic [DATA_W-1:0] fwd [3];
  logic [EW-1:0]     fslot;

  // Oldest-to-youngest scan so later matches win, then same-cycle ALU, then same-cycle load.
  always_comb begin
    fslot = '0;
    for (int q = 0; q < 3; q++) begin
      fwd[q] = '0;
      for (int k = 0; k < DEPTH; k++) begin
        fslot = slots[rdPtr + PW'(k)];
        if ((CW'(k) < Count) && (fslot[EW-1:DATA_W] == qry[q])) fwd[q] = fslot[DATA_W-1:0];
      end
      if (wb.AluValid && (wb.AluReg == qry[q])) fwd[q] = wb.AluData;
      if (wb.MemValid && wb.MemReady && (wb.MemReg == qry[q])) fwd[q] = wb.MemData;
      if (qry[q] == '0) fwd[q] = '0;
    end
  end

  assign FwdDataA = fwd[0];
  assign FwdDataB = fwd[1];
  assign FwdDataC = fwd[2];
`endif
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue: per-cycle vector table plus reset, overflow and forwarding sequences.
module tb_reg_writeback_queue;
  import wb_pkg::*;

  logic CLK;
  logic RESET;
  logic [4:0] QryA, QryB, QryC;
  logic PendA, PendB, PendC;
  logic [2:0] Count;
  logic Overflow;
  logic [4:0] Qry2;
  logic Pend2A, Pend2B, Pend2C;
  logic [1:0] Count2;
  logic Overflow2;
`ifdef WB_FWD_EN
  logic [31:0] FwdDataA, FwdDataB, FwdDataC;
  logic [31:0] Fwd2A, Fwd2B, Fwd2C;
`endif

  int checks = 0;
  int failures = 0;

  reg_writeback_queue_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  reg_writeback_queue_if #(.DATA_W(32), .ADDR_W(5)) bus2 ();

  reg_writeback_queue #(.DEPTH(4), .DATA_W(32), .ADDR_W(5)) dut (
    .CLK(CLK), .RESET(RESET), .wb(bus),
    .QryA(QryA), .QryB(QryB), .QryC(QryC),
    .PendA(PendA), .PendB(PendB), .PendC(PendC),
    .Count(Count),
`ifdef WB_FWD_EN
    .FwdDataA(FwdDataA), .FwdDataB(FwdDataB), .FwdDataC(FwdDataC),
`endif
    .Overflow(Overflow)
  );

  reg_writeback_queue #(.DEPTH(2), .DATA_W(32), .ADDR_W(5)) dut2 (
    .CLK(CLK), .RESET(RESET), .wb(bus2),
    .QryA(Qry2), .QryB(Qry2), .QryC(Qry2),
    .PendA(Pend2A), .PendB(Pend2B), .PendC(Pend2C),
    .Count(Count2),
`ifdef WB_FWD_EN
    .FwdDataA(Fwd2A), .FwdDataB(Fwd2B), .FwdDataC(Fwd2C),
`endif
    .Overflow(Overflow2)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        aluV;
    logic [4:0]  aluReg;
    logic [31:0] aluData;
    logic        memV;
    logic [4:0]  memReg;
    logic [31:0] memData;
    logic [4:0]  qry;
    logic        eW;
    logic [4:0]  eReg;
    logic [31:0] eData;
    logic        eRdy;
    logic        ePend;
    logic [2:0]  eCnt;
  } vec_t;

  vec_t vecs [16];
  wb_entry_t exp2 [2];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic mv, input logic [4:0] mr, input logic [31:0] md);
    bus.AluValid = av; bus.AluReg = ar; bus.AluData = ad;
    bus.MemValid = mv; bus.MemReg = mr; bus.MemData = md;
  endtask

  task automatic drive2(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic mv, input logic [4:0] mr, input logic [31:0] md);
    bus2.AluValid = av; bus2.AluReg = ar; bus2.AluData = ad;
    bus2.MemValid = mv; bus2.MemReg = mr; bus2.MemData = md;
  endtask

  initial begin
    //          aluV reg  data          memV reg  data   qry  eW eReg eData         eRdy ePend eCnt
    vecs[0]  = '{1, 5'd5, 32'hDEADBEEF, 0, 5'd0, 32'h0,  5'd5, 0, 5'd0, 32'h0,        1, 1, 3'd0};
    vecs[1]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  5'd5, 1, 5'd5, 32'hDEADBEEF, 1, 1, 3'd1};
    vecs[2]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  5'd5, 0, 5'd0, 32'h0,        1, 0, 3'd0};
    vecs[3]  = '{1, 5'd3, 32'h11,       1, 5'd3, 32'h22, 5'd3, 0, 5'd0, 32'h0,        1, 1, 3'd0};
    vecs[4]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  5'd3, 1, 5'd3, 32'h11,       1, 1, 3'd2};
    vecs[5]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  5'd3, 1, 5'd3, 32'h22,       1, 1, 3'd1};
    vecs[6]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  5'd3, 0, 5'd0, 32'h0,        1, 0, 3'd0};
    vecs[7]  = '{0, 5'd0, 32'h0,        1, 5'd0, 32'h55, 5'd0, 0, 5'd0, 32'h0,        1, 0, 3'd0};
    vecs[8]  = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  5'd0, 0, 5'd0, 32'h0,        1, 0, 3'd0};
    vecs[9]  = '{1, 5'd1, 32'hA1,       1, 5'd2, 32'hB2, 5'd2, 0, 5'd0, 32'h0,        1, 1, 3'd0};
    vecs[10] = '{1, 5'd4, 32'hA4,       1, 5'd6, 32'hB6, 5'd6, 1, 5'd1, 32'hA1,       1, 1, 3'd2};
    vecs[11] = '{1, 5'd8, 32'hA8,       1, 5'd9, 32'hB9, 5'd9, 1, 5'd2, 32'hB2,       0, 0, 3'd3};
    vecs[12] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  5'd8, 1, 5'd4, 32'hA4,       0, 1, 3'd3};
    vecs[13] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  5'd8, 1, 5'd6, 32'hB6,       1, 1, 3'd2};
    vecs[14] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  5'd8, 1, 5'd8, 32'hA8,       1, 1, 3'd1};
    vecs[15] = '{0, 5'd0, 32'h0,        0, 5'd0, 32'h0,  5'd8, 0, 5'd0, 32'h0,        1, 0, 3'd0};
    exp2[0] = '{idx: 5'd1, data: 32'h101};
    exp2[1] = '{idx: 5'd2, data: 32'h202};

    RESET = 1'b0;
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    drive2(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    QryA = 5'd0; QryB = 5'd0; QryC = 5'd0; Qry2 = 5'd0;
    #12;
    chk("rst_write1", bus.Write1, 1'b0);
    chk("rst_wreg", bus.WriteReg1, 5'd0);
    chk("rst_wdata", bus.WriteData1, 32'h0);
    chk("rst_count", Count, 3'd0);
    chk("rst_memready", bus.MemReady, 1'b1);
    chk("rst_overflow", Overflow, 1'b0);
    @(negedge CLK);
    RESET = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(posedge CLK);
      #1;
      drive(vecs[i].aluV, vecs[i].aluReg, vecs[i].aluData, vecs[i].memV, vecs[i].memReg, vecs[i].memData);
      QryA = vecs[i].qry; QryB = vecs[i].qry; QryC = vecs[i].qry;
      #3;
      chk($sformatf("v%0d_write1", i), bus.Write1, vecs[i].eW);
      chk($sformatf("v%0d_wreg", i), bus.WriteReg1, vecs[i].eReg);
      chk($sformatf("v%0d_wdata", i), bus.WriteData1, vecs[i].eData);
      chk($sformatf("v%0d_memready", i), bus.MemReady, vecs[i].eRdy);
      chk($sformatf("v%0d_pendA", i), PendA, vecs[i].ePend);
      chk($sformatf("v%0d_pendB", i), PendB, vecs[i].ePend);
      chk($sformatf("v%0d_pendC", i), PendC, vecs[i].ePend);
      chk($sformatf("v%0d_count", i), Count, vecs[i].eCnt);
      chk($sformatf("v%0d_overflow", i), Overflow, 1'b0);
    end
    @(posedge CLK);
    #1;
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    QryA = 5'd0; QryB = 5'd0; QryC = 5'd0;

    // Two-entry queue: fill in one cycle, then an ALU result with no free slot is dropped.
    drive2(1, 5'd1, 32'h101, 1, 5'd2, 32'h202);
    Qry2 = 5'd2;
    #3;
    chk("ov_ready_empty", bus2.MemReady, 1'b1);
    chk("ov_pend_arriving", Pend2A, 1'b1);
    @(posedge CLK);
    #1;
    drive2(1, 5'd3, 32'h303, 0, 5'd0, 32'h0);
    Qry2 = 5'd0;
    #3;
    chk("ov_count_full", Count2, 2'd2);
    chk("ov_ready_full", bus2.MemReady, 1'b0);
    chk("ov_wreg0", bus2.WriteReg1, exp2[0].idx);
    chk("ov_wdata0", bus2.WriteData1, exp2[0].data);
    chk("ov_before", Overflow2, 1'b0);
    @(posedge CLK);
    #1;
    drive2(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    Qry2 = 5'd3;
    #3;
    chk("ov_set", Overflow2, 1'b1);
    chk("ov_count_after", Count2, 2'd1);
    chk("ov_wreg1", bus2.WriteReg1, exp2[1].idx);
    chk("ov_wdata1", bus2.WriteData1, exp2[1].data);
    chk("ov_dropped_not_pending", Pend2A, 1'b0);
    @(posedge CLK);
    #4;
    chk("ov_sticky", Overflow2, 1'b1);
    chk("ov_drained_write1", bus2.Write1, 1'b0);
    chk("ov_main_unaffected", Overflow, 1'b0);

    // Reset with three entries queued discards them immediately.
    @(posedge CLK);
    #1;
    drive(1, 5'd1, 32'h1, 1, 5'd2, 32'h2);
    @(posedge CLK);
    #1;
    drive(1, 5'd4, 32'h4, 1, 5'd5, 32'h5);
    @(posedge CLK);
    #1;
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    QryA = 5'd5;
    #1;
    chk("mid_count_pre", Count, 3'd3);
    chk("mid_pend_pre", PendA, 1'b1);
    RESET = 1'b0;
    #1;
    chk("mid_write1", bus.Write1, 1'b0);
    chk("mid_count", Count, 3'd0);
    chk("mid_memready", bus.MemReady, 1'b1);
    chk("mid_wreg", bus.WriteReg1, 5'd0);
    chk("mid_wdata", bus.WriteData1, 32'h0);
    chk("mid_pend", PendA, 1'b0);
    chk("mid_ov2_clear", Overflow2, 1'b0);
    @(negedge CLK);
    RESET = 1'b1;
    @(posedge CLK);
    #4;
    chk("post_rst_count", Count, 3'd0);
    chk("post_rst_write1", bus.Write1, 1'b0);

`ifdef WB_FWD_EN
    @(posedge CLK);
    #1;
    drive(1, 5'd7, 32'h1, 1, 5'd7, 32'h2);
    QryA = 5'd0; QryB = 5'd7; QryC = 5'd7;
    #3;
    chk("fwd_arriving_load_wins", FwdDataB, 32'h2);
    @(posedge CLK);
    #1;
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
    #3;
    chk("fwd_pendB", PendB, 1'b1);
    chk("fwd_youngest", FwdDataB, 32'h2);
    chk("fwd_qry0", FwdDataA, 32'h0);
    @(posedge CLK);
    #1;
    drive(1, 5'd7, 32'h3, 0, 5'd0, 32'h0);
    #3;
    chk("fwd_alu_over_queue", FwdDataC, 32'h3);
    @(posedge CLK);
    #1;
    drive(0, 5'd0, 32'h0, 0, 5'd0, 32'h0);
`endif

    repeat (4) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
